// File: rtl/trace_cmd_dispatch.sv
// Trace command front end: buffers (cmd, addr) pairs, issues them one at a time
// to the LLC model and keeps the read/write/hit/miss statistics.
module trace_cmd_dispatch #(
    parameter int CMDSIZE     = 4,
    parameter int ADDR_BITS   = 32,
    parameter int OFFSET_BITS = 6,
    parameter int INDEX_BITS  = 15,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 32
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [CMDSIZE-1:0]                          in_cmd,
    input  logic [ADDR_BITS-1:0]                        in_addr,
    input  logic                                        eof,
    output logic                                        req_valid,
    input  logic                                        req_ready,
    output logic [CMDSIZE-1:0]                          req_cmd,
    output logic [ADDR_BITS-INDEX_BITS-OFFSET_BITS-1:0] req_tag,
    output logic [INDEX_BITS-1:0]                       req_index,
    output logic [OFFSET_BITS-1:0]                      req_offset,
    input  logic                                        rsp_valid,
    input  logic                                        rsp_hit,
    output logic [CNT_W-1:0]                            reads,
    output logic [CNT_W-1:0]                            writes,
    output logic [CNT_W-1:0]                            cache_hits,
    output logic [CNT_W-1:0]                            cache_misses,
    output logic [CNT_W-1:0]                            bad_cmds,
    output logic                                        done
);

    localparam int TAG_W = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RSP
    } state_t;

    state_t state;

    logic [CMDSIZE-1:0]   cmd_mem  [FIFO_DEPTH];
    logic [ADDR_BITS-1:0] addr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wptr;
    logic [PTR_W-1:0]     rptr;
    logic [PTR_W:0]       count;
    logic                 push;
    logic                 pop;
    logic [CMDSIZE-1:0]   head_cmd;
    logic [ADDR_BITS-1:0] head_addr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic is_bad(input logic [CMDSIZE-1:0] c);
        return (c == CMDSIZE'(7)) || (c > CMDSIZE'(9));
    endfunction

    // Commands 8 and 9 are control commands: no address, no LLC response.
    function automatic logic is_ctl(input logic [CMDSIZE-1:0] c);
        return (c == CMDSIZE'(8)) || (c == CMDSIZE'(9));
    endfunction

    assign in_ready  = (count != FULL_CNT);
    assign push      = in_valid && in_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign head_cmd  = cmd_mem[rptr];
    assign head_addr = addr_mem[rptr];
    assign done      = eof && (count == '0) && (state == IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[wptr]  <= in_cmd;
            addr_mem[wptr] <= in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_W'(1);
            if (pop)  rptr <= rptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_valid    <= 1'b0;
            req_cmd      <= '0;
            req_tag      <= '0;
            req_index    <= '0;
            req_offset   <= '0;
            reads        <= '0;
            writes       <= '0;
            cache_hits   <= '0;
            cache_misses <= '0;
            bad_cmds     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        if (is_bad(head_cmd)) begin
                            bad_cmds <= sat_inc(bad_cmds);
                        end else begin
                            state     <= ISSUE;
                            req_valid <= 1'b1;
                            req_cmd   <= head_cmd;
                            if (is_ctl(head_cmd)) begin
                                req_tag    <= '0;
                                req_index  <= '0;
                                req_offset <= '0;
                            end else begin
                                req_tag    <= head_addr[ADDR_BITS-1 -: TAG_W];
                                req_index  <= head_addr[OFFSET_BITS +: INDEX_BITS];
                                req_offset <= head_addr[OFFSET_BITS-1:0];
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        if ((req_cmd == CMDSIZE'(0)) || (req_cmd == CMDSIZE'(2)))
                            reads <= sat_inc(reads);
                        if (req_cmd == CMDSIZE'(1))
                            writes <= sat_inc(writes);
                        // Later assignments win, so the clear overrides any increment above.
                        if (req_cmd == CMDSIZE'(8)) begin
                            reads        <= '0;
                            writes       <= '0;
                            cache_hits   <= '0;
                            cache_misses <= '0;
                            bad_cmds     <= '0;
                        end
                        state <= is_ctl(req_cmd) ? IDLE : WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_valid) begin
                        if (req_cmd <= CMDSIZE'(2)) begin
                            if (rsp_hit) cache_hits   <= sat_inc(cache_hits);
                            else         cache_misses <= sat_inc(cache_misses);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_cmd_dispatch.sv
// Scoreboard bench for trace_cmd_dispatch: expected requests are queued at
// stimulus time and checked by a monitor at each LLC handshake.
module tb_trace_cmd_dispatch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cmd;
    logic [31:0] in_addr;
    logic        eof;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_cmd;
    logic [10:0] req_tag;
    logic [14:0] req_index;
    logic [5:0]  req_offset;
    logic        rsp_valid;
    logic        rsp_hit;
    logic [31:0] reads;
    logic [31:0] writes;
    logic [31:0] cache_hits;
    logic [31:0] cache_misses;
    logic [31:0] bad_cmds;
    logic        done;

    logic auto_valid, auto_hit, man_valid, man_hit, auto_rsp;
    assign rsp_valid = auto_valid | man_valid;
    assign rsp_hit   = auto_valid ? auto_hit : man_hit;

    int total = 0;
    int bad   = 0;
    int hs_rsp_cnt = 0;
    int rsp_sent   = 0;

    logic [35:0] exp_q[$];
    logic        hit_q[$];

    trace_cmd_dispatch #(
        .CMDSIZE    (4),
        .ADDR_BITS  (32),
        .OFFSET_BITS(6),
        .INDEX_BITS (15),
        .FIFO_DEPTH (4),
        .CNT_W      (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cmd      (in_cmd),
        .in_addr     (in_addr),
        .eof         (eof),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cmd     (req_cmd),
        .req_tag     (req_tag),
        .req_index   (req_index),
        .req_offset  (req_offset),
        .rsp_valid   (rsp_valid),
        .rsp_hit     (rsp_hit),
        .reads       (reads),
        .writes      (writes),
        .cache_hits  (cache_hits),
        .cache_misses(cache_misses),
        .bad_cmds    (bad_cmds),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Push one command; iss=1 queues the hand-computed request fields.
    task automatic push(input logic [3:0] c, input logic [31:0] a, input bit iss,
                        input logic [10:0] tg, input logic [14:0] ix, input logic [5:0] of);
        bit ok = 0;
        if (iss) exp_q.push_back({c, tg, ix, of});
        in_cmd   = c;
        in_addr  = a;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("push_timeout", 0, 1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0 && rsp_sent == hs_rsp_cnt) begin
                ok = 1;
                break;
            end
            step();
        end
        if (!ok) check("drain_timeout", 0, 1);
        repeat (3) step();
    endtask

    task automatic check_cnts(input string tag, input int r, input int w,
                              input int h, input int m, input int b);
        check({tag, "_reads"},  reads,        r);
        check({tag, "_writes"}, writes,       w);
        check({tag, "_hits"},   cache_hits,   h);
        check({tag, "_misses"}, cache_misses, m);
        check({tag, "_bad"},    bad_cmds,     b);
    endtask

    // Monitor: handshake compare against the scoreboard plus stall stability.
    initial begin
        logic        stalled = 0;
        logic [35:0] held    = '0;
        logic [35:0] cur;
        logic [35:0] e;
        forever begin
            @(negedge clk);
            cur = {req_cmd, req_tag, req_index, req_offset};
            if (rst) begin
                stalled = 0;
            end else begin
                if (stalled) begin
                    check("stall_valid", req_valid, 1);
                    check("stall_hold", cur, held);
                end
                stalled = 0;
                if (req_valid) begin
                    if (req_ready) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_req", cur, 36'h0);
                            check("unexpected_req_valid", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("req", cur, e);
                        end
                        if (req_cmd <= 4'd6) hs_rsp_cnt++;
                    end else begin
                        stalled = 1;
                        held    = cur;
                    end
                end
            end
        end
    end

    // LLC responder: one pulse the cycle after each handshake needing a response.
    initial begin
        auto_valid = 0;
        auto_hit   = 0;
        forever begin
            step();
            auto_valid = 0;
            if (!auto_rsp) begin
                rsp_sent = hs_rsp_cnt;
            end else if (hs_rsp_cnt > rsp_sent) begin
                auto_valid = 1;
                auto_hit   = (hit_q.size() != 0) ? hit_q.pop_front() : 1'b0;
                rsp_sent++;
            end
        end
    end

    initial begin
        bit ok;
        rst = 1; in_valid = 0; in_cmd = '0; in_addr = '0; eof = 0;
        req_ready = 1; man_valid = 0; man_hit = 0; auto_rsp = 0;
        repeat (3) step();
        check("rst_in_ready", in_ready, 1);
        check("rst_req_valid", req_valid, 0);
        check("rst_done", done, 0);
        check_cnts("rst", 0, 0, 0, 0, 0);
        rst = 0;
        step();

        // Reset while waiting for a response
        push(4'd0, 32'h10019d94, 1, 11'h080, 15'h0676, 6'h14);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (hs_rsp_cnt == 1) begin ok = 1; break; end
            step();
        end
        if (!ok) check("t1_hs_timeout", 0, 1);
        step();
        rst = 1;
        step();
        rst = 0;
        step();
        check("t1_req_valid", req_valid, 0);
        check("t1_in_ready", in_ready, 1);
        check_cnts("t1", 0, 0, 0, 0, 0);
        man_valid = 1; man_hit = 1;
        step();
        man_valid = 0; man_hit = 0;
        step();
        check("t1_late_rsp_hits", cache_hits, 0);
        auto_rsp = 1;
        step();

        // Basic stream: miss, hit, miss
        hit_q.push_back(0); hit_q.push_back(1); hit_q.push_back(0);
        push(4'd0, 32'h10019d94, 1, 11'h080, 15'h0676, 6'h14);
        push(4'd1, 32'h10019d94, 1, 11'h080, 15'h0676, 6'h14);
        push(4'd2, 32'h00408ed4, 1, 11'h002, 15'h023b, 6'h14);
        drain();
        check_cnts("t2", 2, 1, 1, 2, 0);

        // Backpressure: FIFO fills, request held stable
        req_ready = 0;
        hit_q.push_back(1); hit_q.push_back(1); hit_q.push_back(0);
        hit_q.push_back(1); hit_q.push_back(0);
        push(4'd0, 32'h00000000, 1, 11'h000, 15'h0000, 6'h00);
        push(4'd1, 32'hffffffff, 1, 11'h7ff, 15'h7fff, 6'h3f);
        push(4'd2, 32'h00000040, 1, 11'h000, 15'h0001, 6'h00);
        push(4'd0, 32'h80000000, 1, 11'h400, 15'h0000, 6'h00);
        push(4'd1, 32'h0020003f, 1, 11'h001, 15'h0000, 6'h3f);
        step();
        check("t3_full_in_ready", in_ready, 0);
        check("t3_req_valid", req_valid, 1);
        check("t3_req_cmd", req_cmd, 0);
        req_ready = 1;
        drain();
        check("t3_in_ready", in_ready, 1);
        check_cnts("t3", 5, 3, 4, 4, 0);

        // Three reads, then clear
        hit_q.push_back(1); hit_q.push_back(1); hit_q.push_back(1);
        push(4'd0, 32'h00000100, 1, 11'h000, 15'h0004, 6'h00);
        push(4'd2, 32'h00001234, 1, 11'h000, 15'h0048, 6'h34);
        push(4'd0, 32'h0007ffc0, 1, 11'h000, 15'h1fff, 6'h00);
        drain();
        check_cnts("t4_pre", 8, 3, 7, 4, 0);
        push(4'd8, 32'hdeadbeef, 1, 11'h000, 15'h0000, 6'h00);
        drain();
        check_cnts("t4_clr", 0, 0, 0, 0, 0);

        // Illegal commands dropped; snoop counts nothing
        hit_q.push_back(1);
        push(4'd7,  32'h00000001, 0, '0, '0, '0);
        push(4'd12, 32'h00000002, 0, '0, '0, '0);
        push(4'd3,  32'h00000abc, 1, 11'h000, 15'h002a, 6'h3c);
        drain();
        check_cnts("t5", 0, 0, 0, 0, 2);

        // Completion flag
        eof = 1;
        hit_q.push_back(0); hit_q.push_back(0);
        push(4'd1, 32'h00000040, 1, 11'h000, 15'h0001, 6'h00);
        push(4'd2, 32'h00000080, 1, 11'h000, 15'h0002, 6'h00);
        check("t6_done_pending", done, 0);
        drain();
        check("t6_done", done, 1);
        check_cnts("t6", 1, 1, 0, 2, 2);
        eof = 0;
        step();
        check("t6_done_drop", done, 0);
        check("t6_in_ready_after", in_ready, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
